// File: rtl/siso_shift_ctrl.sv
// Serial-out sequencer: takes WIDTH-bit words over valid/ready and shifts them out MSB-first.
// Optional even-parity trailer bit when SISO_PARITY_EN is defined.
module siso_shift_ctrl #(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_in_ready,
    input  logic             i_stall,
    output logic             o_s_out,
    output logic             o_s_en,
    output logic             o_busy,
    output logic             o_done
);

`ifdef SISO_PARITY_EN
    localparam int FRAME_W = WIDTH + 1;
`else
    localparam int FRAME_W = WIDTH;
`endif

    localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    logic [FRAME_W-1:0] r_shift;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [CNT_W-1:0]   r_gap_cnt;
    logic               r_s_out;
    logic               r_s_en;
    logic               r_done;

    state_t             w_state_nxt;
    logic [FRAME_W-1:0] w_shift_nxt;
    logic [CNT_W-1:0]   w_bit_cnt_nxt;
    logic [CNT_W-1:0]   w_gap_cnt_nxt;
    logic               w_s_out_nxt;
    logic               w_s_en_nxt;
    logic               w_done_nxt;
    logic [FRAME_W-1:0] w_load;

`ifdef SISO_PARITY_EN
    function automatic logic f_parity(input logic [WIDTH-1:0] data);
        return ^data;
    endfunction

    assign w_load = {i_in_data, f_parity(i_in_data)};
`else
    assign w_load = i_in_data;
`endif

    assign o_in_ready = (r_state == ST_IDLE);
    assign o_busy     = (r_state != ST_IDLE);
    assign o_s_out    = r_s_out;
    assign o_s_en     = r_s_en;
    assign o_done     = r_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_s_out   <= 1'b0;
            r_s_en    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_s_out   <= w_s_out_nxt;
            r_s_en    <= w_s_en_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Outputs are registered, so each edge computes what the next cycle presents;
    // r_shift holds the bits still to be presented, next one at the MSB.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_s_out_nxt   = r_s_out;
        w_s_en_nxt    = 1'b0;
        w_done_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_s_out_nxt = 1'b0;
                if (i_in_valid) begin
                    w_state_nxt   = ST_SHIFT;
                    w_s_out_nxt   = w_load[FRAME_W-1];
                    w_s_en_nxt    = 1'b1;
                    w_shift_nxt   = w_load << 1;
                    w_bit_cnt_nxt = BIT_LOAD;
                end
            end
            ST_SHIFT: begin
                if (!i_stall) begin
                    if (r_bit_cnt == '0) begin
                        w_done_nxt  = 1'b1;
                        w_s_out_nxt = 1'b0;
                        w_shift_nxt = '0;
                        if (GAP_CYCLES > 0) begin
                            w_state_nxt   = ST_GAP;
                            w_gap_cnt_nxt = GAP_LOAD;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_s_out_nxt   = r_shift[FRAME_W-1];
                        w_s_en_nxt    = 1'b1;
                        w_shift_nxt   = r_shift << 1;
                        w_bit_cnt_nxt = r_bit_cnt - CNT_ONE;
                    end
                end
            end
            ST_GAP: begin
                w_s_out_nxt = 1'b0;
                if (r_gap_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Bench for siso_shift_ctrl: directed frame scenarios plus randomized traffic against a queue model.
module tb_siso_shift_ctrl;

`ifdef SISO_PARITY_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif
    localparam int G1 = 1;
    localparam int G0 = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       stall = 1'b0;

    logic rdy1, sout1, sen1, busy1, done1;
    logic rdy0, sout0, sen0, busy0, done0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    siso_shift_ctrl #(.WIDTH(4), .GAP_CYCLES(G1), .CNT_W(4)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .i_in_data(in_data),
        .o_in_ready(rdy1), .i_stall(stall), .o_s_out(sout1), .o_s_en(sen1),
        .o_busy(busy1), .o_done(done1)
    );

    siso_shift_ctrl #(.WIDTH(4), .GAP_CYCLES(G0), .CNT_W(4)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .i_in_data(in_data),
        .o_in_ready(rdy0), .i_stall(stall), .o_s_out(sout0), .o_s_en(sen0),
        .o_busy(busy0), .o_done(done0)
    );

    // {s_en, s_out, done, in_ready, busy}
    wire [4:0] obs1 = {sen1, sout1, done1, rdy1, busy1};
    wire [4:0] obs0 = {sen0, sout0, done0, rdy0, busy0};

    // Bit i of the serial frame for word w: data MSB-first, then the parity trailer.
    function automatic logic exp_bit(input logic [3:0] w, input int i);
        if (i < 4) return w[3-i];
        return ^w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        stall    = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        stall = 1'b0;
        tick();
        total++;
        if ({sen1, sout1, done1, busy1} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_dut1 got en/out/done/busy=%b exp=0000", {sen1, sout1, done1, busy1});
        end
        total++;
        if ({sen0, sout0, done0, busy0} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_dut0 got en/out/done/busy=%b exp=0000", {sen0, sout0, done0, busy0});
        end
        rst_n = 1'b1;
        #1;
        total++;
        if ({rdy1, rdy0} !== 2'b11) begin
            bad++;
            $display("FAIL reset_ready got %b exp 11", {rdy1, rdy0});
        end
    endtask

    task automatic test_word(input logic [3:0] w);
        logic [4:0] exp;
        do_reset();
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
        in_data  = ~w;
        for (int k = 1; k <= FL + G1 + 2; k++) begin
            exp[4] = (k <= FL);
            exp[3] = (k <= FL) ? exp_bit(w, k - 1) : 1'b0;
            exp[2] = (k == FL + 1);
            exp[1] = (k >= FL + 1 + G1);
            exp[0] = !exp[1];
            total++;
            if (obs1 !== exp) begin
                bad++;
                $display("FAIL word_%b k=%0d got en/out/done/rdy/busy=%b exp=%b", w, k, obs1, exp);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [3:0] w;
        logic [4:0] exp;
        w = 4'b1001;
        do_reset();
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= FL + G1 + 5; k++) begin
            stall = (k >= 1 && k <= 3);
            exp[4] = (k == 1) || (k >= 5 && k <= FL + 3);
            if (k <= 4)           exp[3] = exp_bit(w, 0);
            else if (k <= FL + 3) exp[3] = exp_bit(w, k - 4);
            else                  exp[3] = 1'b0;
            exp[2] = (k == FL + 4);
            exp[1] = (k >= FL + 4 + G1);
            exp[0] = !exp[1];
            total++;
            if (obs1 !== exp) begin
                bad++;
                $display("FAIL stall k=%0d got en/out/done/rdy/busy=%b exp=%b", k, obs1, exp);
            end
            tick();
        end
        stall = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [4:0] exp;
        do_reset();
        in_valid = 1'b1;
        in_data  = 4'b1111;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        // mid-cycle, well away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({sen1, sout1, done1, busy1} !== 4'b0000) begin
            bad++;
            $display("FAIL async_clear got en/out/done/busy=%b exp=0000", {sen1, sout1, done1, busy1});
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({sen1, done1} !== 2'b00) begin
                bad++;
                $display("FAIL async_hold k=%0d got en/done=%b exp=00", k, {sen1, done1});
            end
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (rdy1 !== 1'b1) begin
            bad++;
            $display("FAIL async_ready got %b exp 1", rdy1);
        end
        in_valid = 1'b1;
        in_data  = 4'b0101;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= FL + 1; k++) begin
            exp[4] = (k <= FL);
            exp[3] = (k <= FL) ? exp_bit(4'b0101, k - 1) : 1'b0;
            exp[2] = (k == FL + 1);
            exp[1] = (k >= FL + 1 + G1);
            exp[0] = !exp[1];
            total++;
            if (obs1 !== exp) begin
                bad++;
                $display("FAIL async_next k=%0d got en/out/done/rdy/busy=%b exp=%b", k, obs1, exp);
            end
            tick();
        end
    endtask

    // Valid held continuously: second word is taken only when in_ready returns.
    task automatic test_two_frames(input int g, input logic [3:0] w1, input logic [3:0] w2);
        logic [4:0] exp;
        logic [4:0] got;
        int s2;
        int dones;
        s2 = FL + g + 2;
        dones = 0;
        do_reset();
        in_valid = 1'b1;
        in_data  = w1;
        tick();
        in_data = w2;
        for (int k = 1; k <= 2 * FL + g + 3; k++) begin
            if (k == s2) in_valid = 1'b0;
            got = (g == 0) ? obs0 : obs1;
            exp[4] = (k <= FL) || (k >= s2 && k < s2 + FL);
            if (k <= FL)                  exp[3] = exp_bit(w1, k - 1);
            else if (k >= s2 && k < s2 + FL) exp[3] = exp_bit(w2, k - s2);
            else                          exp[3] = 1'b0;
            exp[2] = (k == FL + 1) || (k == s2 + FL);
            exp[1] = (k == FL + 1 + g) || (k >= s2 + FL + g);
            exp[0] = !exp[1];
            if (got[2] === 1'b1) dones++;
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL two_frames_g%0d k=%0d got en/out/done/rdy/busy=%b exp=%b", g, k, got, exp);
            end
            tick();
        end
        total++;
        if (dones != 2) begin
            bad++;
            $display("FAIL two_frames_g%0d done_count got %0d exp 2", g, dones);
        end
    endtask

    task automatic test_random();
        logic       v, s;
        logic [3:0] d;
        logic       q[$];
        int         phase;
        int         gap_left;
        logic       e_out, e_en, e_done;
        logic [4:0] exp;
        do_reset();
        phase = 0;
        gap_left = 0;
        e_out = 1'b0;
        for (int c = 0; c < 400; c++) begin
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 3) == 0);
            d = 4'($urandom);
            in_valid = v;
            in_data  = d;
            stall    = s;
            tick();
            e_en = 1'b0;
            e_done = 1'b0;
            case (phase)
                0: begin
                    e_out = 1'b0;
                    if (v) begin
                        q.delete();
                        for (int i = 0; i < FL; i++) q.push_back(exp_bit(d, i));
                        e_out = q.pop_front();
                        e_en = 1'b1;
                        phase = 1;
                    end
                end
                1: begin
                    if (!s) begin
                        if (q.size() == 0) begin
                            e_done = 1'b1;
                            e_out = 1'b0;
                            gap_left = G1;
                            phase = (G1 > 0) ? 2 : 0;
                        end else begin
                            e_out = q.pop_front();
                            e_en = 1'b1;
                        end
                    end
                end
                default: begin
                    gap_left--;
                    if (gap_left == 0) phase = 0;
                end
            endcase
            exp = {e_en, e_out, e_done, (phase == 0), (phase != 0)};
            total++;
            if (obs1 !== exp) begin
                bad++;
                $display("FAIL random c=%0d got en/out/done/rdy/busy=%b exp=%b", c, obs1, exp);
            end
        end
        in_valid = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_word(4'b1010);
        test_word(4'b1011);
        test_word(4'b1001);
        test_stall();
        test_async_reset();
        test_two_frames(G1, 4'b1100, 4'b0011);
        test_two_frames(G0, 4'b0110, 4'b1011);
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
